// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NUM_REQ producers.
// Each grant carries up to MAX_BURST words and never writes while fifo_full.
module fifo_write_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 16,
  parameter int MAX_BURST = 4,
  localparam int IW = $clog2(NUM_REQ),
  localparam int CW = $clog2(MAX_BURST + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     fifo_write,
  output logic [WIDTH-1:0]         fifo_data_in,
  input  logic                     fifo_full,
  output logic [IW-1:0]            grant_id,
  output logic                     busy
);

  typedef enum logic {
    IDLE,
    OWN
  } state_e;

  state_e          state_q;
  logic [IW-1:0]   owner_q;
  logic [IW-1:0]   last_q;
  logic [CW-1:0]   burst_q;

  logic [WIDTH-1:0] words [NUM_REQ];
  logic             own;
  logic             own_vld;
  logic             xfer;
  logic             win_vld;
  logic [IW-1:0]    win_idx;
  logic [IW-1:0]    cand;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_words
    assign words[g] = req_data[g*WIDTH +: WIDTH];
  end

  assign own     = (state_q == OWN);
  assign own_vld = req_valid[owner_q];
  assign xfer    = own && own_vld && !fifo_full;

  // Scan starts just after the last released owner, wrapping.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = last_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (cand == IW'(NUM_REQ - 1)) ? '0 : cand + IW'(1);
      if (!win_vld && req_valid[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  assign req_ready    = (own && !fifo_full) ?
                        (NUM_REQ'(1) << owner_q) : '0;
  assign fifo_write   = xfer;
  assign fifo_data_in = xfer ? words[owner_q] : '0;
  assign grant_id     = owner_q;
  assign busy         = own;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= IW'(NUM_REQ - 1);
      burst_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (win_vld) begin
            owner_q <= win_idx;
            burst_q <= '0;
            state_q <= OWN;
          end
        end
        OWN: begin
          if (!own_vld) begin
            state_q <= IDLE;
            last_q  <= owner_q;
          end else if (xfer) begin
            burst_q <= burst_q + CW'(1);
            if (burst_q == CW'(MAX_BURST - 1)) begin
              state_q <= IDLE;
              last_q  <= owner_q;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Bench for fifo_write_arbiter: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_fifo_write_arbiter;

  localparam int NR = 4;
  localparam int W  = 16;
  localparam int MB = 4;
  localparam int IW = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NR-1:0]     req_valid = '0;
  logic [NR*W-1:0]   req_data = '0;
  logic [NR-1:0]     req_ready;
  logic              fifo_write;
  logic [W-1:0]      fifo_data_in;
  logic              fifo_full = 1'b0;
  logic [IW-1:0]     grant_id;
  logic              busy;

  fifo_write_arbiter #(
    .NUM_REQ  (NR),
    .WIDTH    (W),
    .MAX_BURST(MB)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .fifo_write  (fifo_write),
    .fifo_data_in(fifo_data_in),
    .fifo_full   (fifo_full),
    .grant_id    (grant_id),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Behavioural model: who owns the port and how many words it has moved.
  int m_busy, m_owner, m_last, m_cnt;
  int pend [NR];
  int seq  [NR];
  bit drop [NR];
  bit chk_en = 1'b0;

  int            cyc;
  logic [63:0]   wv, bv;
  logic [IW-1:0] gv [64];
  logic [NR-1:0] rv [64];
  logic [W-1:0]  dv [64];
  logic [W-1:0]  wq [$];
  int            bad_ready;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [W-1:0] word(input int i);
    return {4'(i), 12'(256 + seq[i])};
  endfunction

  task automatic model_reset();
    m_busy  = 0;
    m_owner = 0;
    m_last  = NR - 1;
    m_cnt   = 0;
  endtask

  task automatic model_step();
    bit xf;
    bit found;
    if (rst) begin
      model_reset();
    end else begin
      xf = (m_busy != 0) && req_valid[m_owner] && !fifo_full;
      if (xf) begin
        pend[m_owner]--;
        seq[m_owner]++;
      end
      if (m_busy == 0) begin
        found = 1'b0;
        for (int k = 1; k <= NR; k++) begin
          if (!found && req_valid[(m_last + k) % NR]) begin
            found   = 1'b1;
            m_owner = (m_last + k) % NR;
            m_busy  = 1;
            m_cnt   = 0;
          end
        end
      end else if (!req_valid[m_owner]) begin
        m_busy = 0;
        m_last = m_owner;
      end else if (xf) begin
        m_cnt++;
        if (m_cnt == MB) begin
          m_busy = 0;
          m_last = m_owner;
        end
      end
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      req_valid[i] = (pend[i] > 0) && !drop[i];
      req_data[i*W +: W] = req_valid[i] ? word(i) : W'($urandom);
    end
  endtask

  task automatic tick();
    drive();
    #3;
    if (cyc < 64) begin
      wv[cyc] = fifo_write;
      bv[cyc] = busy;
      gv[cyc] = grant_id;
      rv[cyc] = req_ready;
      dv[cyc] = fifo_data_in;
    end
    if (fifo_write) wq.push_back(fifo_data_in);
    if ((req_ready & ~(NR'(1) << grant_id)) != '0) bad_ready++;
    cyc++;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic new_test(input string nm);
    rst = 1'b1;
    model_reset();
    for (int i = 0; i < NR; i++) begin
      pend[i] = 0;
      seq[i]  = 0;
      drop[i] = 1'b0;
    end
    fifo_full = 1'b0;
    tick();
    chk({nm, "_reset"}, {busy, fifo_write, req_ready, grant_id, fifo_data_in},
        '0);
    rst = 1'b0;
    cyc = 0;
    wv = '0;
    bv = '0;
    wq.delete();
    bad_ready = 0;
  endtask

  // Per-cycle comparison against the model, mid-cycle with inputs settled.
  logic          e_w;
  logic [NR-1:0] e_r;
  logic [W-1:0]  e_d;
  always @(negedge clk) begin
    if (chk_en) begin
      #2;
      e_w = (m_busy != 0) && req_valid[m_owner] && !fifo_full;
      e_r = (m_busy != 0 && !fifo_full) ? (NR'(1) << m_owner) : '0;
      e_d = e_w ? req_data[m_owner*W +: W] : '0;
      checks++;
      if (fifo_write !== e_w || req_ready !== e_r || fifo_data_in !== e_d ||
          busy !== (m_busy != 0) || grant_id !== IW'(m_owner)) begin
        failures++;
        $display("FAIL cycle_model t=%0t actual w=%b r=%b d=%h b=%b g=%0d expected w=%b r=%b d=%h b=%0d g=%0d",
                 $time, fifo_write, req_ready, fifo_data_in, busy, grant_id,
                 e_w, e_r, e_d, m_busy, m_owner);
      end
    end
  end

  initial begin
    model_reset();
    @(negedge clk);
    chk_en = 1'b1;

    // Single producer bursting: 4 words, idle, then the remaining 2.
    new_test("t1");
    pend[2] = 6;
    repeat (10) tick();
    chk("t1_write", wv[7:0], 8'hDE);
    chk("t1_busy", bv[7:0], 8'hDE);
    chk("t1_gid", {gv[1], gv[4], gv[6], gv[7]}, 8'b10101010);
    chk("t1_count", wq.size(), 6);
    for (int k = 0; k < 6; k++)
      chk("t1_word", (k < wq.size()) ? wq[k] : 16'hxxxx, 16'h2100 + 16'(k));

    // Full rotation with everyone valid.
    new_test("t2");
    for (int i = 0; i < NR; i++) pend[i] = 100;
    repeat (25) tick();
    chk("t2_write", wv[24:0], 25'b1111011110111101111011110);
    chk("t2_order", {gv[2], gv[7], gv[12], gv[17], gv[22]}, 10'b0001101100);
    chk("t2_nonowner", bad_ready, 0);

    // Stall on full after the second word.
    new_test("t3");
    pend[1] = 8;
    for (int c = 0; c < 9; c++) begin
      fifo_full = (c >= 3 && c <= 5);
      tick();
    end
    chk("t3_write", wv[8:0], 9'b011000110);
    chk("t3_busy", bv[8:0], 9'b011111110);
    chk("t3_stall_ready", {rv[3], rv[4], rv[5]}, '0);
    chk("t3_gid", {gv[3], gv[4], gv[5]}, 6'b010101);
    chk("t3_count", wq.size(), 4);
    if (wq.size() == 4)
      chk("t3_words", {wq[0], wq[1], wq[2], wq[3]},
          {16'h1100, 16'h1101, 16'h1102, 16'h1103});

    // Early valid drop forfeits the grant.
    new_test("t4");
    pend[1] = 2;
    pend[3] = 100;
    for (int c = 0; c < 11; c++) begin
      if (c == 6) pend[1] = 5;
      tick();
    end
    chk("t4_write", wv[10:0], 11'b10111100110);
    chk("t4_busy", bv[10:0], 11'b10111101110);
    chk("t4_gid", {gv[3], gv[5], gv[10]}, 6'b011101);
    chk("t4_drop_data", dv[3], '0);

    // Asynchronous reset in the middle of a burst.
    new_test("t5");
    pend[2] = 100;
    repeat (3) tick();
    drive();
    #3;
    chk("t5_pre_write", fifo_write, 1'b1);
    #1;
    rst = 1'b1;
    model_reset();
    #1;
    chk("t5_async", {fifo_write, req_ready, busy, grant_id}, '0);
    @(posedge clk);
    model_step();
    #1;
    chk("t5_edge", {fifo_write, busy}, '0);
    @(negedge clk);
    pend[2] = 0;
    pend[0] = 10;
    pend[3] = 10;
    rst = 1'b0;
    cyc = 0;
    wv = '0;
    bv = '0;
    repeat (3) tick();
    chk("t5_first", {bv[1], gv[1], wv[1], dv[1]},
        {1'b1, 2'd0, 1'b1, 16'h0100});

    // Full asserted while arbitrating.
    new_test("t6");
    pend[1] = 5;
    for (int c = 0; c < 4; c++) begin
      fifo_full = (c < 3);
      tick();
    end
    chk("t6_busy", bv[3:0], 4'b1110);
    chk("t6_gid", gv[1], 1);
    chk("t6_ready", {rv[0][1], rv[1][1], rv[2][1], rv[3][1]}, 4'b0001);
    chk("t6_write", wv[3:0], 4'b1000);

    // Randomized traffic against the model.
    new_test("rand");
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NR; i++) begin
        drop[i] = 1'b0;
        if (pend[i] == 0 && $urandom_range(3) == 0)
          pend[i] = int'($urandom_range(7, 1));
        if ($urandom_range(39) == 0) drop[i] = 1'b1;
      end
      fifo_full = ($urandom_range(3) == 0);
      if ($urandom_range(499) == 0) begin
        rst = 1'b1;
        model_reset();
      end else begin
        rst = 1'b0;
      end
      tick();
    end
    chk("rand_nonowner", bad_ready, 0);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
